// File: rtl/aes_arb_pkg.sv
// Shared types and constants for the AES request arbiter.
package aes_arb_pkg;

  localparam int AES_BLK_W = 128;
  localparam int GRANT_W   = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter
  import aes_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GRANT_W-1:0] ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [GRANT_W-1:0] idx,
  output logic               any
);

  localparam logic [GRANT_W:0] NREQ = (GRANT_W+1)'(NUM_REQ);

  logic [NUM_REQ-1:0] rot;
  logic [GRANT_W:0]   off;
  logic [GRANT_W:0]   sum;

  // Rotate so ptr sits at bit 0, take the lowest set bit, then map back.
  always_comb begin
    rot = NUM_REQ'({req, req} >> ptr);
    off = '0;
    any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off = (GRANT_W+1)'(k);
        any = 1'b1;
      end
    end
    sum = {1'b0, ptr} + off;
    if (sum >= NREQ) begin
      sum = sum - NREQ;
    end
    idx = sum[GRANT_W-1:0];
    gnt = any ? (NUM_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/aes_req_arbiter.sv
// Shares one aes_core among NUM_REQ requesters with round-robin grant.
// One transaction in flight: IDLE (arbitrate) -> ISSUE (start pulse)
// -> WAIT (core done) -> RESP (valid/ready back to the granted requester).
// Optional build macro AES_ARB_TIMEOUT_EN: bounds WAIT to TIMEOUT_CYC cycles
// and answers with rsp_err=1, rsp_data=0 when the core never finishes.
module aes_req_arbiter
  import aes_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*AES_BLK_W-1:0] req_pt,
  input  logic [NUM_REQ*AES_BLK_W-1:0] req_key,
  output logic [NUM_REQ-1:0]           rsp_valid,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic [AES_BLK_W-1:0]         rsp_data,
  output logic                         rsp_err,
  output logic [GRANT_W-1:0]           grant_id,
  output logic                         busy,
  output logic                         aes_start,
  output logic [AES_BLK_W-1:0]         aes_plaintext,
  output logic [AES_BLK_W-1:0]         aes_key,
  input  logic [AES_BLK_W-1:0]         aes_ciphertext,
  input  logic                         aes_done
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 2) begin : g_param_err
    $error("aes_req_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC >= 2");
  end

  state_t               state_q, state_d;
  logic [GRANT_W-1:0]   ptr_q, ptr_next, win_idx;
  logic [NUM_REQ-1:0]   win_gnt;
  logic                 win_any;
  logic [AES_BLK_W-1:0] pt_sel, key_sel;
  logic                 accept, rsp_hs, done_hit, timeout_hit;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (win_gnt),
    .idx (win_idx),
    .any (win_any)
  );

  // One-hot AND-OR mux of the winner's plaintext and key.
  always_comb begin
    pt_sel  = '0;
    key_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_gnt[k]) begin
        pt_sel  = pt_sel  | req_pt[k*AES_BLK_W +: AES_BLK_W];
        key_sel = key_sel | req_key[k*AES_BLK_W +: AES_BLK_W];
      end
    end
  end

  assign req_ready = (state_q == S_IDLE) ? win_gnt : '0;
  assign accept    = (state_q == S_IDLE) && win_any;
  assign aes_start = (state_q == S_ISSUE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_RESP) ? (NUM_REQ'(1) << grant_id) : '0;
  // Masking with rsp_valid drops rsp_ready from non-granted requesters.
  assign rsp_hs    = |(rsp_valid & rsp_ready);
  // Done outside WAIT (stray or late pulse) is not looked at.
  assign done_hit  = (state_q == S_WAIT) && aes_done;
  assign ptr_next  = (grant_id == GRANT_W'(NUM_REQ - 1)) ? '0 : grant_id + GRANT_W'(1);

`ifdef AES_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  logic [CNT_W-1:0] wait_cnt;
  logic             rsp_err_q;

  // Last allowed WAIT cycle without done ends the wait with an error.
  assign timeout_hit = (state_q == S_WAIT) && !aes_done &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign rsp_err     = rsp_err_q;

  // WAIT-cycle counter, cleared whenever the FSM is elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state_q != S_WAIT) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Error flag is decided at the moment WAIT ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err_q <= 1'b0;
    end else if (done_hit) begin
      rsp_err_q <= 1'b0;
    end else if (timeout_hit) begin
      rsp_err_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (done_hit || timeout_hit) state_d = S_RESP;
      S_RESP:  if (rsp_hs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and round-robin pointer; pointer advances past the served requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (rsp_hs) begin
        ptr_q <= ptr_next;
      end
    end
  end

  // Capture the winner's operands and identity on the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_id      <= '0;
      aes_plaintext <= '0;
      aes_key       <= '0;
    end else if (accept) begin
      grant_id      <= win_idx;
      aes_plaintext <= pt_sel;
      aes_key       <= key_sel;
    end
  end

  // Response data: core result on done, zero on timeout; held through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
    end else if (done_hit) begin
      rsp_data <= aes_ciphertext;
    end else if (timeout_hit) begin
      rsp_data <= '0;
    end
  end

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Randomized bench for aes_req_arbiter with a behavioural round-robin model
// and a one-cycle-latency core stub (ciphertext = plaintext ^ key).
module tb_aes_req_arbiter;
  import aes_arb_pkg::*;

  localparam int N  = 4;
  localparam int TO = 64;
  localparam int B  = AES_BLK_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [N*B-1:0]   req_pt = '0;
  logic [N*B-1:0]   req_key = '0;
  logic [N-1:0]     rsp_valid;
  logic [N-1:0]     rsp_ready = '0;
  logic [B-1:0]     rsp_data;
  logic             rsp_err;
  logic [GRANT_W-1:0] grant_id;
  logic             busy;
  logic             aes_start;
  logic [B-1:0]     aes_plaintext;
  logic [B-1:0]     aes_key;
  logic [B-1:0]     aes_ciphertext = '0;
  logic             aes_done = 1'b0;

  logic stub_stuck = 1'b0;
  logic stray      = 1'b0;

  int total = 0;
  int bad   = 0;
  int mptr  = 0;

  aes_req_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_pt         (req_pt),
    .req_key        (req_key),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err),
    .grant_id       (grant_id),
    .busy           (busy),
    .aes_start      (aes_start),
    .aes_plaintext  (aes_plaintext),
    .aes_key        (aes_key),
    .aes_ciphertext (aes_ciphertext),
    .aes_done       (aes_done)
  );

  always #5 clk = ~clk;

  // Core stub: done one cycle after start, or a forced stray pulse.
  always @(posedge clk) begin
    if (stray) begin
      aes_done       <= 1'b1;
      aes_ciphertext <= {4{32'hdeadbeef}};
    end else if (aes_start && !stub_stuck) begin
      aes_done       <= 1'b1;
      aes_ciphertext <= aes_plaintext ^ aes_key;
    end else begin
      aes_done <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [B-1:0] got, input logic [B-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    return N'(1) << i;
  endfunction

  // Reference arbitration: first valid index from ptr upward, wrapping.
  function automatic int model_win(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++) begin
      if (m[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [B-1:0] r128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic rand_operands();
    for (int i = 0; i < N; i++) begin
      req_pt[i*B +: B]  = r128();
      req_key[i*B +: B] = r128();
    end
  endtask

  // One full transaction from IDLE, starting and ending at a falling edge.
  task automatic run_txn(input logic [N-1:0] mask, input int hold, input bit stuck);
    int           w;
    int           n;
    logic [B-1:0] exp_data;
    w = model_win(mask, mptr);
    exp_data = stuck ? '0 : (req_pt[w*B +: B] ^ req_key[w*B +: B]);
    req_valid = mask;
    #1;
    chk("req_ready", req_ready, oh(w));
    chk("idle_busy", busy, 0);
    @(posedge clk);
    @(negedge clk);
    chk("aes_start", aes_start, 1);
    chk("issue_ready", req_ready, 0);
    chk("grant_id", grant_id, w);
    chk("aes_pt", aes_plaintext, req_pt[w*B +: B]);
    chk("aes_key", aes_key, req_key[w*B +: B]);
    n = 0;
    while (rsp_valid == '0 && n < 200) begin
      @(negedge clk);
      n++;
      chk("wait_ready", req_ready, 0);
    end
    chk("rsp_latency", n, stuck ? TO + 1 : 2);
    chk("rsp_valid", rsp_valid, oh(w));
    chk("rsp_data", rsp_data, exp_data);
    chk("rsp_err", rsp_err, stuck);
    for (int h = 0; h < hold; h++) begin
      rsp_ready = N'($urandom()) & ~oh(w);
      @(negedge clk);
      chk("hold_valid", rsp_valid, oh(w));
      chk("hold_data", rsp_data, exp_data);
      chk("hold_ready", req_ready, 0);
    end
    rsp_ready = oh(w) | N'($urandom());
    @(negedge clk);
    rsp_ready = '0;
    mptr = (w + 1) % N;
    chk("rsp_cleared", rsp_valid, 0);
    chk("back_idle", busy, 0);
  endtask

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] m, pre;

    // Reset state
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_start", aes_start, 0);
    chk("rst_pt", aes_plaintext, 0);
    chk("rst_key", aes_key, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request with known operands
    req_pt[B-1:0]  = 128'h1;
    req_key[B-1:0] = 128'h3;
    run_txn(4'b0001, 0, 1'b0);
    chk("t1_data", rsp_data, 128'h2);
    req_valid = '0;

    // Response back-pressure for 10 cycles
    rand_operands();
    run_txn(4'b0010, 10, 1'b0);
    req_valid = '0;

    // Stray done in IDLE must not produce a response
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    @(negedge clk);
    chk("stray_rsp", rsp_valid, 0);
    chk("stray_busy", busy, 0);
    rand_operands();
    run_txn(4'b0100, 1, 1'b0);

    // Reset while in WAIT, then all requesters from a fresh pointer
    rand_operands();
    req_valid = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rsp", rsp_valid, 0);
    chk("mid_rst_start", aes_start, 0);
    chk("mid_rst_pt", aes_plaintext, 0);
    chk("mid_rst_grant", grant_id, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mptr = 0;
    @(negedge clk);
    chk("post_rst_rsp", rsp_valid, 0);

    for (int k = 0; k < 5; k++) begin
      rand_operands();
      run_txn(4'b1111, k % 2, 1'b0);
      chk("rr_order", grant_id, order[k]);
    end
    req_valid = '0;

    // Randomized traffic
    for (int t = 0; t < 30; t++) begin
      rand_operands();
      m = N'($urandom_range(1, (1 << N) - 1));
      if ($urandom_range(0, 2) == 0) begin
        req_valid = '0;
        @(negedge clk);
        chk("gap_busy", busy, 0);
      end
      if ($urandom_range(0, 2) == 0) begin
        pre = N'($urandom_range(1, (1 << N) - 1));
        req_valid = pre;
        #1;
        chk("pre_ready", req_ready, oh(model_win(pre, mptr)));
      end
      run_txn(m, $urandom_range(0, 3), 1'b0);
    end
    req_valid = '0;

`ifdef AES_ARB_TIMEOUT_EN
    // Core never finishes: timeout answer
    rand_operands();
    stub_stuck = 1'b1;
    run_txn(4'b0001, 2, 1'b1);
    stub_stuck = 1'b0;
    req_valid = '0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
